// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx serializer among N byte streams.
// The owner keeps the serializer until its byte flagged last has finished on the line.
module uart_tx_arbiter #(
    parameter int          N            = 4,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd1000,
    parameter int          IW           = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_vld,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_rdy,
    output logic [N-1:0]   grant,
    output logic [7:0]     uart_data,
    output logic           uart_vld,
    input  logic           uart_ready,
    output logic           busy,
    output logic           err_timeout,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_onehot;
    logic          win_found;
    logic          own_vld;
    logic          own_last;
    logic [7:0]    own_data;
    logic [15:0]   tmo_cnt;
    logic          last_flag;
    logic          handshake;
    logic          tmo_hit;
    logic          byte_done;

    // Winner is the requester at the smallest rotational distance after last_owner.
    always_comb begin
        int best_d;
        int d;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        best_d     = N;
        d          = 0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - 1 - int'(last_owner)) % N;
            if (req_vld[i] && d < best_d) begin
                best_d    = d;
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            win_onehot[i] = (win_idx == IW'(i));
        end
    end

    always_comb begin
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_data = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                own_vld  = req_vld[i];
                own_last = req_last[i];
                own_data = req_data[8*i +: 8];
            end
        end
    end

    assign handshake = (state == SEND) && own_vld && uart_ready;
    assign tmo_hit   = (state == WAIT_BUSY) && uart_ready && (tmo_cnt == BUSY_TIMEOUT - 16'd1);
    assign byte_done = tmo_hit || ((state == WAIT_DONE) && uart_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (win_found) state_nx = SEND;
            SEND:      if (handshake) state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!uart_ready)   state_nx = WAIT_DONE;
                else if (tmo_hit)  state_nx = last_flag ? IDLE : SEND;
            end
            WAIT_DONE: if (byte_done) state_nx = last_flag ? IDLE : SEND;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < N; i++) begin
            req_rdy[i] = (state == SEND) && (owner == IW'(i)) && req_vld[i] && uart_ready;
        end
        busy      = (state != IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= '0;
            last_owner  <= IW'(N - 1);
            grant       <= '0;
            uart_data   <= 8'h00;
            uart_vld    <= 1'b0;
            last_flag   <= 1'b0;
            tmo_cnt     <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            uart_vld    <= handshake;
            err_timeout <= tmo_hit;
            if (state == IDLE && win_found) begin
                owner <= win_idx;
                grant <= win_onehot;
            end
            if (handshake) begin
                uart_data <= own_data;
                last_flag <= own_last;
                tmo_cnt   <= 16'd0;
            end else if (state == WAIT_BUSY) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (byte_done && last_flag) begin
                last_owner <= owner;
                grant      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte sources, a serializer model and
// a byte monitor feed scenario tasks that compare against hand-computed tables.
module tb_uart_tx_arbiter;
    localparam int          N   = 4;
    localparam logic [15:0] TMO = 16'd40;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_vld;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   grant;
    logic [7:0]     uart_data;
    logic           uart_vld;
    logic           uart_ready;
    logic           busy;
    logic           err_timeout;
    logic [1:0]     dbg_state;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(TMO), .IW(3)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
        .req_rdy(req_rdy), .grant(grant), .uart_data(uart_data), .uart_vld(uart_vld),
        .uart_ready(uart_ready), .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // requester sources: {last, data} per entry
    logic [8:0] src_mem [N][16];
    int src_rd [N];
    int src_wr [N];
    logic [N-1:0] hs;

    task automatic push(input int i, input logic [7:0] d, input logic l);
        src_mem[i][src_wr[i]] = {l, d};
        src_wr[i]++;
    endtask

    function automatic bit drained();
        for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [8:0] ent;
        req_vld = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
        forever begin
            @(negedge clk);
            hs = req_vld & req_rdy;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) src_rd[i]++;
                if (src_rd[i] < src_wr[i]) begin
                    ent = src_mem[i][src_rd[i]];
                    req_vld[i] = 1'b1;
                    req_data[8*i +: 8] = ent[7:0];
                    req_last[i] = ent[8];
                end else begin
                    req_vld[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // serializer model: ready drops 2 cycles after uart_vld, stays low 20 cycles
    int ser_t = -1;
    logic ser_stuck = 1'b0;

    initial begin
        uart_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ser_t >= 0) begin
                ser_t++;
                if (ser_t == 2) uart_ready = 1'b0;
                else if (ser_t == 22) begin uart_ready = 1'b1; ser_t = -1; end
            end else if (uart_vld && !ser_stuck) begin
                ser_t = 0;
            end
        end
    end

    // monitor / scoreboard capture
    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];
    int vld_s_q [$];
    int tmo_s_q [$];
    int smp = 0;
    int vld_rise_s = -1, rdy_rise_s = -1, uvld_s = -1, ready_rise_s = -1, busy_fall_s = -1;
    int rdy_bad = 0;
    logic prev_ready = 1'b1, prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            smp++;
            if (uart_vld) begin
                got_q.push_back({grant, uart_data});
                vld_s_q.push_back(smp);
                if (uvld_s < 0) uvld_s = smp;
            end
            if (err_timeout) tmo_s_q.push_back(smp);
            if (req_vld != '0 && vld_rise_s < 0) vld_rise_s = smp;
            if (req_rdy != '0 && rdy_rise_s < 0) rdy_rise_s = smp;
            if ($countones(req_rdy) > 1 || (req_rdy & ~grant) != '0) rdy_bad++;
            if (uart_ready && !prev_ready) ready_rise_s = smp;
            if (!busy && prev_busy) busy_fall_s = smp;
            prev_ready = uart_ready;
            prev_busy = busy;
        end
    end

    task automatic clear_sb();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
        got_q.delete(); exp_q.delete(); vld_s_q.delete(); tmo_s_q.delete();
        vld_rise_s = -1; rdy_rise_s = -1; uvld_s = -1; ready_rise_s = -1; busy_fall_s = -1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(drained() && busy === 1'b0 && uart_ready === 1'b1 && ser_t < 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; failures++;
            $display("FAIL %s_idle_wait expired after %0d cycles busy=%b", name, n, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    // scenario tasks
    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL reset_uart_data got=%h exp=00", uart_data); end
        checks++; if (uart_vld !== 1'b0) begin failures++; $display("FAIL reset_uart_vld got=%b exp=0", uart_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_packet();
        clear_sb();
        push(0, 8'h48, 1'b0); push(0, 8'h49, 1'b0); push(0, 8'h0A, 1'b1);
        exp_q.push_back(12'h148); exp_q.push_back(12'h149); exp_q.push_back(12'h10A);
        wait_idle(400, "single");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (rdy_rise_s - vld_rise_s != 1) begin failures++; $display("FAIL single_vld_to_rdy got=%0d exp=1", rdy_rise_s - vld_rise_s); end
        checks++; if (uvld_s - rdy_rise_s != 1) begin failures++; $display("FAIL single_rdy_to_uvld got=%0d exp=1", uvld_s - rdy_rise_s); end
        checks++; if (busy_fall_s - ready_rise_s < 1 || busy_fall_s - ready_rise_s > 2) begin
            failures++; $display("FAIL single_busy_release got=%0d exp=1..2", busy_fall_s - ready_rise_s);
        end
    endtask

    task automatic test_contention();
        do_reset();
        clear_sb();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        exp_q.push_back(12'h211); exp_q.push_back(12'h212); exp_q.push_back(12'h421); exp_q.push_back(12'h422);
        wait_idle(600, "contention");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL contention_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL contention_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        // last_owner=2 now, so requester 3 must beat requester 1
        clear_sb();
        push(1, 8'h13, 1'b1); push(3, 8'h33, 1'b1);
        exp_q.push_back(12'h833); exp_q.push_back(12'h213);
        wait_idle(400, "wrap");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL wrap_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_fairness();
        logic [11:0] tbl [8];
        tbl = '{12'h1A0, 12'h2B0, 12'h4C0, 12'h8D0, 12'h1A1, 12'h2B1, 12'h4C1, 12'h8D1};
        do_reset();
        clear_sb();
        for (int i = 0; i < N; i++) begin
            push(i, 8'hA0 + 8'(16 * i), 1'b1);
            push(i, 8'hA1 + 8'(16 * i), 1'b1);
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(tbl[k]);
        wait_idle(800, "fairness");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fair_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL fair_pkt%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_owner_stall();
        int n = 0;
        do_reset();
        clear_sb();
        push(0, 8'h01, 1'b0); push(3, 8'h31, 1'b1);
        while (got_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin checks++; failures++; $display("FAIL stall_first_byte wait expired got=%0d", got_q.size()); end
        repeat (50) @(negedge clk);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL stall_no_vld got=%0d exp=1", got_q.size()); end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL stall_grant got=%b exp=0001", grant); end
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL stall_req_rdy got=%b exp=0000", req_rdy); end
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL stall_state got=%0d exp=1", dbg_state); end
        push(0, 8'h02, 1'b1);
        exp_q.push_back(12'h101); exp_q.push_back(12'h102); exp_q.push_back(12'h831);
        wait_idle(400, "stall");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_timeout();
        ser_stuck = 1'b1;
        do_reset();
        clear_sb();
        push(0, 8'h55, 1'b0); push(0, 8'h56, 1'b1);
        exp_q.push_back(12'h155); exp_q.push_back(12'h156);
        wait_idle(600, "timeout");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL tmo_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL tmo_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (tmo_s_q.size() != 2) begin failures++; $display("FAIL tmo_pulses got=%0d exp=2", tmo_s_q.size()); end
        if (tmo_s_q.size() == 2 && vld_s_q.size() == 2) begin
            checks++; if (tmo_s_q[0] - vld_s_q[0] != 40) begin failures++; $display("FAIL tmo_delay0 got=%0d exp=40", tmo_s_q[0] - vld_s_q[0]); end
            checks++; if (tmo_s_q[1] - vld_s_q[1] != 40) begin failures++; $display("FAIL tmo_delay1 got=%0d exp=40", tmo_s_q[1] - vld_s_q[1]); end
            checks++; if (vld_s_q[1] - tmo_s_q[0] != 1) begin failures++; $display("FAIL tmo_advance got=%0d exp=1", vld_s_q[1] - tmo_s_q[0]); end
        end
        ser_stuck = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        int n = 0;
        do_reset();
        clear_sb();
        push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b1);
        while (!(got_q.size() >= 2 && dbg_state == 2'd3) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin checks++; failures++; $display("FAIL rstmid_wait expired state=%0d bytes=%0d", dbg_state, got_q.size()); end
        rst = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rstmid_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (uart_vld !== 1'b0) begin failures++; $display("FAIL rstmid_uart_vld got=%b exp=0", uart_vld); end
        checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL rstmid_uart_data got=%h exp=00", uart_data); end
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        while (grant == 4'b0000 && n < 50) begin @(negedge clk); n++; end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rstmid_regrant got=%b exp=0001", grant); end
        exp_q.push_back(12'h161); exp_q.push_back(12'h162); exp_q.push_back(12'h163);
        wait_idle(400, "rstmid");
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_contention();
        test_fairness();
        test_owner_stall();
        test_timeout();
        test_reset_mid_packet();
        checks++; if (rdy_bad != 0) begin failures++; $display("FAIL rdy_onehot_owner got=%0d bad cycles exp=0", rdy_bad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
